ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Consumer end of the decode-stage control bundle.
- Captures the per-instruction control word produced in DECO, then carries it through the EXE, MEM and WB pipeline registers.
- Applies stall and branch-flush, and derives EXE operand-forwarding selects from downstream destination registers.
- Sits between the decoder and the EXE/MEM/WB datapath muxes, the memory enable and the register-file write port.

Parameters:
- REG_ADDR_W, 5, register index width.
- ALU_CTRL_W, 3, ALU operation select width.
- CNT_W, 16, width of the saturating flush/bubble counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reg_write_d  in  1  decode: register-file write enable.
- alu_src_d  in  1  decode: 1 = immediate operand B.
- branch_d  in  1  decode: instruction is a branch.
- alu_ctrl_d  in  ALU_CTRL_W  decode: ALU operation.
- mem_ctrl_d  in  2  decode: {enable, write}.
- rs1_d, rs2_d, rd_d  in  REG_ADDR_W each  decode: register indices.
- stall_i  in  1  hold the instruction currently in EXE.
- branch_taken_e  in  1  branch resolved taken in EXE this cycle.
- alu_src_e, branch_e  out  1 each  EXE controls.
- alu_ctrl_e  out  ALU_CTRL_W  EXE ALU select.
- forward_a_e, forward_b_e  out  2 each  operand source: 00 regfile, 10 MEM result, 01 WB result.
- mem_ctrl_m  out  2  MEM controls.
- reg_write_w  out  1  WB write enable.
- rd_w  out  REG_ADDR_W  WB destination.
- flush_count  out  CNT_W  bubbles inserted since reset, saturating.

Behaviour:
- Reset: asynchronous on rst_n low. Every stage register clears to bubble: all enables 0, alu_ctrl 0, register indices 0. flush_count clears to 0. All outputs therefore reset to 0.
- Bubble definition: reg_write=0, mem_ctrl=00, branch=0, alu_src=0, alu_ctrl=0, rd/rs1/rs2=0.
- Normal advance, each rising edge: D->E, E->M, M->W. Latency from the decode inputs:
  - E outputs valid after 1 cycle.
  - mem_ctrl_m valid after 2 cycles.
  - reg_write_w/rd_w valid after 3 cycles.
- stall_i=1 (and no flush):
  - E register holds its contents.
  - M loads a bubble.
  - W loads from M as normal.
  - flush_count increments.
  - Decode inputs are ignored for that edge; upstream holds them.
- branch_taken_e=1:
  - E loads a bubble, killing the instruction in decode.
  - M loads the branch instruction from E as normal.
  - flush_count increments.
- Simultaneous stall_i and branch_taken_e: flush wins. E loads a bubble, M loads from E, and flush_count increments exactly once.
- flush_count saturates at all-ones and does not wrap.
- Forwarding is combinational from registered state only. There is no combinational path from the _d inputs to the forward selects.
  - forward_a_e = 10 when reg_write_m, rd_m != 0 and rd_m == rs1_e.
  - Otherwise forward_a_e = 01 when reg_write_w, rd_w != 0 and rd_w == rs1_e.
  - Otherwise forward_a_e = 00.
  - forward_b_e follows the same rule with rs2_e.
  - MEM has priority over WB.
  - x0 is never forwarded.
- Stores: reg_write=0, so they are never forwarding sources.
- Reset asserted mid-operation: all in-flight instructions are discarded immediately. The first instruction after release appears at E one edge after decode presents it.

Decomposition:
- Shared package ctrl_pkg:
  - MEM_CTRL encodings: MEM_NONE=00, MEM_WRITE=11.
  - FWD_* select constants: FWD_RF=00, FWD_MEM=10, FWD_WB=01.
  - The packed control-word layout and the BUBBLE constant.
- One natural sub-module, ctrl_fwd_unit: the purely combinational forwarding compare, instantiated twice (operand A, operand B).
- The stage registers and flush_count stay in ctrl_pipe.

Test Plan:
- Reset: rst_n low mid-stream with non-zero controls in all stages -> every output is 0 immediately, without waiting for a clock edge. flush_count=0.
- Straight-line: ALU op (reg_write_d=1, alu_ctrl_d=3'b111, rd_d=5) -> alu_ctrl_e=111 at edge 1, mem_ctrl_m=00 at edge 2, reg_write_w=1 with rd_w=5 at edge 3.
- Forwarding:
  - rd=3 write followed by rs1_d=3 -> forward_a_e=10.
  - Insert one independent instruction between them -> 01.
  - rd=0 writer -> 00.
  - Writers at both MEM and WB with rd=3 -> 10.
- Stall: stall_i for 2 cycles with an instruction in E -> E outputs held, two bubbles in MEM (mem_ctrl_m=00), flush_count=2.
- Flush: branch_taken_e=1 with a store (mem_ctrl_d=11) in decode -> the store never reaches MEM; mem_ctrl_m stays 00. The branch itself reaches MEM. flush_count +1.
- Priority and saturation:
  - stall_i and branch_taken_e in the same cycle -> E loads a bubble, count +1.
  - Preload a CNT_W=4 build to 15, then flush -> count stays 15.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the decode-to-writeback control pipeline.
// This package holds the control-word layouts, the bubble value and the select encodings.
package ctrl_pkg;
  localparam int CTRL_REG_W = 5;
  localparam int CTRL_ALU_W = 3;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b10;
  localparam logic [1:0] MEM_WRITE = 2'b11;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            mem_ctrl;
    logic                  branch;
    logic                  alu_src;
    logic [CTRL_ALU_W-1:0] alu_ctrl;
    logic [CTRL_REG_W-1:0] rs1;
    logic [CTRL_REG_W-1:0] rs2;
    logic [CTRL_REG_W-1:0] rd;
  } ctrl_t;

  // Later stages keep only the fields their consumers still need.
  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            mem_ctrl;
    logic [CTRL_REG_W-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic                  reg_write;
    logic [CTRL_REG_W-1:0] rd;
  } wb_t;

  localparam ctrl_t BUBBLE     = '0;
  localparam mem_t  MEM_BUBBLE = '0;
endpackage

// File: rtl/ctrl_fwd_unit.sv
// This unit selects the forwarding source for one EXE operand.
// A MEM-stage writer takes priority over a WB-stage writer, and x0 is never forwarded.
module ctrl_fwd_unit
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = CTRL_REG_W
) (
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic                  reg_write_m,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_w,
  input  logic [REG_ADDR_W-1:0] rd_w,
  output logic [1:0]            fwd
);
  always_comb begin
    fwd = FWD_RF;
    if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) fwd = FWD_WB;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) fwd = FWD_MEM;
  end
endmodule

// File: rtl/ctrl_pipe.sv
// This module carries the decoded control word through the EXE, MEM and WB stages.
// It applies stall and branch-flush, counts inserted bubbles and drives the operand forwarding selects.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = CTRL_REG_W,
  parameter int ALU_CTRL_W = CTRL_ALU_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_write_d,
  input  logic                  alu_src_d,
  input  logic                  branch_d,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl_d,
  input  logic [1:0]            mem_ctrl_d,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  stall_i,
  input  logic                  branch_taken_e,
  output logic                  alu_src_e,
  output logic                  branch_e,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_e,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic [1:0]            mem_ctrl_m,
  output logic                  reg_write_w,
  output logic [REG_ADDR_W-1:0] rd_w,
  output logic [CNT_W-1:0]      flush_count
);
  ctrl_t e_q, e_d, dec;
  mem_t  m_q, m_d;
  wb_t   w_q;
  logic  hold_e;

  // A flush overrides a stall, so a stall holds EXE only when no branch is taken.
  assign hold_e = stall_i & ~branch_taken_e;

  always_comb begin
    dec           = BUBBLE;
    dec.reg_write = reg_write_d;
    dec.mem_ctrl  = mem_ctrl_d;
    dec.branch    = branch_d;
    dec.alu_src   = alu_src_d;
    dec.alu_ctrl  = alu_ctrl_d;
    dec.rs1       = rs1_d;
    dec.rs2       = rs2_d;
    dec.rd        = rd_d;

    e_d = dec;
    if (branch_taken_e) e_d = BUBBLE;
    else if (stall_i)   e_d = e_q;

    m_d = hold_e ? MEM_BUBBLE : '{reg_write: e_q.reg_write, mem_ctrl: e_q.mem_ctrl, rd: e_q.rd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q         <= BUBBLE;
      m_q         <= MEM_BUBBLE;
      w_q         <= '0;
      flush_count <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= '{reg_write: m_q.reg_write, rd: m_q.rd};
      if ((stall_i || branch_taken_e) && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end

  assign alu_src_e   = e_q.alu_src;
  assign branch_e    = e_q.branch;
  assign alu_ctrl_e  = e_q.alu_ctrl;
  assign mem_ctrl_m  = m_q.mem_ctrl;
  assign reg_write_w = w_q.reg_write;
  assign rd_w        = w_q.rd;

  // Forwarding unit 0 serves operand A (rs1) and unit 1 serves operand B (rs2).
  logic [1:0][REG_ADDR_W-1:0] rs_e;
  logic [1:0][1:0]            fwd;

  assign rs_e = {e_q.rs2, e_q.rs1};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    ctrl_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
      .rs_e        (rs_e[g]),
      .reg_write_m (m_q.reg_write),
      .rd_m        (m_q.rd),
      .reg_write_w (w_q.reg_write),
      .rd_w        (w_q.rd),
      .fwd         (fwd[g])
    );
  end

  assign forward_a_e = fwd[0];
  assign forward_b_e = fwd[1];
endmodule

// File: tb/tb_ctrl_pipe.sv
// This is a directed self-checking bench for ctrl_pipe.
// A second instance with a 4-bit counter shares the same stimulus so that saturation can be observed.
module tb_ctrl_pipe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       reg_write_d, alu_src_d, branch_d;
  logic [2:0] alu_ctrl_d;
  logic [1:0] mem_ctrl_d;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       stall_i, branch_taken_e;

  logic        alu_src_e, branch_e, reg_write_w;
  logic [2:0]  alu_ctrl_e;
  logic [1:0]  forward_a_e, forward_b_e, mem_ctrl_m;
  logic [4:0]  rd_w;
  logic [15:0] flush_count;

  logic        alu_src_e4, branch_e4, reg_write_w4;
  logic [2:0]  alu_ctrl_e4;
  logic [1:0]  forward_a_e4, forward_b_e4, mem_ctrl_m4;
  logic [4:0]  rd_w4;
  logic [3:0]  flush_count4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .reg_write_d(reg_write_d), .alu_src_d(alu_src_d),
    .branch_d(branch_d), .alu_ctrl_d(alu_ctrl_d), .mem_ctrl_d(mem_ctrl_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .stall_i(stall_i),
    .branch_taken_e(branch_taken_e), .alu_src_e(alu_src_e), .branch_e(branch_e),
    .alu_ctrl_e(alu_ctrl_e), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .mem_ctrl_m(mem_ctrl_m), .reg_write_w(reg_write_w), .rd_w(rd_w),
    .flush_count(flush_count)
  );

  ctrl_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .reg_write_d(reg_write_d), .alu_src_d(alu_src_d),
    .branch_d(branch_d), .alu_ctrl_d(alu_ctrl_d), .mem_ctrl_d(mem_ctrl_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .stall_i(stall_i),
    .branch_taken_e(branch_taken_e), .alu_src_e(alu_src_e4), .branch_e(branch_e4),
    .alu_ctrl_e(alu_ctrl_e4), .forward_a_e(forward_a_e4), .forward_b_e(forward_b_e4),
    .mem_ctrl_m(mem_ctrl_m4), .reg_write_w(reg_write_w4), .rd_w(rd_w4),
    .flush_count(flush_count4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input logic rw, input logic asrc, input logic br, input logic [2:0] alu,
                      input logic [1:0] mem, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd);
    reg_write_d = rw;  alu_src_d = asrc; branch_d = br; alu_ctrl_d = alu;
    mem_ctrl_d  = mem; rs1_d = r1; rs2_d = r2; rd_d = rd;
  endtask

  task automatic clrd();
    setd(0, 0, 0, 3'd0, 2'b00, 5'd0, 5'd0, 5'd0);
  endtask

  function automatic logic [63:0] all_out();
    return {alu_src_e, branch_e, alu_ctrl_e, forward_a_e, forward_b_e, mem_ctrl_m,
            reg_write_w, rd_w, flush_count,
            alu_src_e4, branch_e4, alu_ctrl_e4, forward_a_e4, forward_b_e4, mem_ctrl_m4,
            reg_write_w4, rd_w4, flush_count4};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; branch_taken_e = 1'b0;
    clrd();
    #12;
    chk("reset_init", all_out(), 64'h0);
    rst_n = 1'b1;
    tick();

    // Straight-line ALU op: E after 1 edge, M after 2, W after 3.
    setd(1, 0, 0, 3'b111, 2'b00, 5'd0, 5'd0, 5'd5);
    tick();
    chk("sl_alu_e", alu_ctrl_e, 3'b111);
    clrd();
    tick();
    chk("sl_mem_m", mem_ctrl_m, 2'b00);
    chk("sl_e_drained", alu_ctrl_e, 3'b000);
    tick();
    chk("sl_wb", {reg_write_w, rd_w}, {1'b1, 5'd5});

    // Back-to-back dependency forwards from MEM.
    setd(1, 0, 0, 3'd1, 2'b00, 5'd0, 5'd0, 5'd3);
    tick();
    setd(0, 0, 0, 3'd2, 2'b00, 5'd3, 5'd0, 5'd0);
    tick();
    chk("fwd_mem_a", forward_a_e, 2'b10);
    chk("fwd_mem_b_none", forward_b_e, 2'b00);

    // One independent instruction in between forwards from WB.
    setd(1, 0, 0, 3'd1, 2'b00, 5'd0, 5'd0, 5'd4);
    tick();
    setd(1, 0, 0, 3'd1, 2'b00, 5'd1, 5'd0, 5'd6);
    tick();
    setd(0, 0, 0, 3'd0, 2'b00, 5'd0, 5'd4, 5'd0);
    tick();
    chk("fwd_wb_b", forward_b_e, 2'b01);
    chk("fwd_wb_a_none", forward_a_e, 2'b00);

    // A writer to x0 never forwards.
    setd(1, 0, 0, 3'd1, 2'b00, 5'd0, 5'd0, 5'd0);
    tick();
    setd(0, 0, 0, 3'd0, 2'b00, 5'd0, 5'd0, 5'd0);
    tick();
    chk("fwd_x0", {forward_a_e, forward_b_e}, 4'b0000);

    // When writers are in both MEM and WB, MEM wins.
    setd(1, 0, 0, 3'd1, 2'b00, 5'd0, 5'd0, 5'd3);
    tick();
    tick();
    setd(0, 0, 0, 3'd0, 2'b00, 5'd3, 5'd3, 5'd0);
    tick();
    chk("fwd_prio", {forward_a_e, forward_b_e}, 4'b1010);
    clrd();
    tick(); tick(); tick();
    chk("cnt_zero", flush_count, 16'd0);

    // Stall for two cycles with a load in EXE.
    setd(1, 0, 0, 3'd5, 2'b10, 5'd1, 5'd0, 5'd7);
    tick();
    chk("st_load_e", alu_ctrl_e, 3'd5);
    stall_i = 1'b1;
    setd(0, 0, 0, 3'd2, 2'b00, 5'd0, 5'd0, 5'd0);
    tick();
    chk("st1_hold", {alu_ctrl_e, mem_ctrl_m, flush_count}, {3'd5, 2'b00, 16'd1});
    tick();
    chk("st2_hold", {alu_ctrl_e, mem_ctrl_m, flush_count}, {3'd5, 2'b00, 16'd2});
    stall_i = 1'b0;
    tick();
    chk("st_release", {alu_ctrl_e, mem_ctrl_m, flush_count}, {3'd2, 2'b10, 16'd2});

    // A taken branch kills the store in decode while the branch itself proceeds.
    setd(1, 0, 1, 3'd1, 2'b00, 5'd2, 5'd3, 5'd9);
    tick();
    chk("fl_branch_e", branch_e, 1'b1);
    branch_taken_e = 1'b1;
    setd(0, 1, 0, 3'd4, 2'b11, 5'd1, 5'd2, 5'd0);
    tick();
    chk("fl_e_bubble", {branch_e, alu_src_e, alu_ctrl_e, flush_count}, {1'b0, 1'b0, 3'd0, 16'd3});
    branch_taken_e = 1'b0;
    clrd();
    tick();
    chk("fl_no_store", {mem_ctrl_m, reg_write_w, rd_w}, {2'b00, 1'b1, 5'd9});

    // Simultaneous stall and flush: the flush wins and is counted once.
    setd(1, 0, 0, 3'd6, 2'b00, 5'd0, 5'd0, 5'd2);
    tick();
    chk("pr_e", alu_ctrl_e, 3'd6);
    stall_i = 1'b1; branch_taken_e = 1'b1;
    setd(0, 0, 0, 3'd4, 2'b00, 5'd0, 5'd0, 5'd0);
    tick();
    chk("pr_e_bubble", {alu_ctrl_e, flush_count}, {3'd0, 16'd4});
    stall_i = 1'b0; branch_taken_e = 1'b0;
    clrd();
    tick();
    chk("pr_m_loaded", {reg_write_w, rd_w}, {1'b1, 5'd2});

    // Saturation: the 4-bit counter stops at 15.
    stall_i = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    stall_i = 1'b0;
    chk("sat_cnt4", flush_count4, 4'd15);
    chk("sat_cnt16", flush_count, 16'd16);
    branch_taken_e = 1'b1;
    tick();
    branch_taken_e = 1'b0;
    chk("sat_hold", {flush_count4, flush_count}, {4'd15, 16'd17});

    // Assert reset mid-stream with every stage loaded.
    setd(1, 1, 1, 3'd7, 2'b11, 5'd3, 5'd3, 5'd3);
    tick(); tick(); tick();
    chk("pre_rst", {reg_write_w, mem_ctrl_m, forward_a_e, alu_src_e}, {1'b1, 2'b11, 2'b10, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", all_out(), 64'h0);
    setd(0, 0, 0, 3'd3, 2'b00, 5'd0, 5'd0, 5'd0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("rst_first", {alu_ctrl_e, mem_ctrl_m, flush_count}, {3'd3, 2'b00, 16'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
